// File: rtl/cnt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_ctrl_pkg
// Description : Shared op encodings and FSM state encoding for cnt_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_ctrl_pkg;

    localparam logic [1:0] OP_CLEAR   = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_COUNT   = 2'b10;
    localparam logic [1:0] OP_CAPTURE = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_LD   = 3'd2;
    localparam logic [2:0] ST_CNT  = 3'd3;
    localparam logic [2:0] ST_CAP  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CLR  = ST_CLR,
        S_LD   = ST_LD,
        S_CNT  = ST_CNT,
        S_CAP  = ST_CAP,
        S_DONE = ST_DONE
    } state_t;

endpackage : cnt_ctrl_pkg
`default_nettype wire

// File: rtl/cnt_shadow.sv
`default_nettype none
// ============================================================================
// Module      : cnt_shadow
// Description : Shadow of the external up/down counter, driven from the same
//               registered control lines, with sticky wrap detection.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_shadow
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cclr_n,
    input  logic             load_n,
    input  logic             en_n,
    input  logic             updown,
    input  logic [WIDTH-1:0] datain,
    input  logic             wrap_clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] C_MAX  = '1;
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (wrap_clr) begin
                r_wrap <= 1'b0;
            end
            // Clear beats load beats count, matching the counter's priority.
            if (!cclr_n) begin
                r_count <= '0;
            end else if (!load_n) begin
                r_count <= datain;
            end else if (!en_n) begin
                if (updown) begin
                    r_count <= r_count + 1'b1;
                    if (r_count == C_MAX) begin
                        r_wrap <= 1'b1;
                    end
                end else begin
                    r_count <= r_count - 1'b1;
                    if (r_count == C_ZERO) begin
                        r_wrap <= 1'b1;
                    end
                end
            end
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

endmodule : cnt_shadow
`default_nettype wire

// File: rtl/cnt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnt_seq_ctrl
// Description : Command sequencer for a 4-bit up/down counter with storage
//               register; drives its active-low controls and shadows its value.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_seq_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_dir,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              cclr_n,
    output logic              load_n,
    output logic              enp_n,
    output logic              ent_n,
    output logic              updown,
    output logic [WIDTH-1:0]  datain,
    output logic              rck,
    output logic              g_n,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  count,
    output logic              wrap
);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_cnt_last;
    logic              w_en_next;
    logic [STEP_W-1:0] w_steps_next;

    logic [STEP_W-1:0] r_steps;
    logic [STEP_W-1:0] r_step;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_cclr_n;
    logic              r_load_n;
    logic              r_en_n;
    logic              r_updown;
    logic [WIDTH-1:0]  r_datain;
    logic              r_rck;
    logic              r_g_n;

    always_comb begin
        w_accept     = (r_state == S_IDLE) && cmd_valid;
        w_steps_next = w_accept ? cmd_steps : r_steps;
        w_cnt_last   = (r_steps == '0) ||
                       (({1'b0, r_step} + 1'b1) == {1'b0, r_steps});
        w_next       = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_CLEAR: w_next = S_CLR;
                        OP_LOAD:  w_next = S_LD;
                        OP_COUNT: w_next = S_CNT;
                        default:  w_next = S_CAP;
                    endcase
                end
            end
            S_CLR, S_LD, S_CAP: w_next = S_DONE;
            S_CNT: begin
                if (w_cnt_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // A zero-step COUNT still spends one cycle in CNT, with enables off.
        w_en_next = (w_next == S_CNT) && (w_steps_next != '0);
    end

    // Outputs are registered from the next state so each control line is
    // valid for the whole cycle its state occupies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_steps  <= '0;
            r_step   <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cclr_n <= 1'b1;
            r_load_n <= 1'b1;
            r_en_n   <= 1'b1;
            r_updown <= 1'b1;
            r_datain <= '0;
            r_rck    <= 1'b0;
            r_g_n    <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_ready  <= (w_next == S_IDLE);
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_DONE);
            r_cclr_n <= (w_next != S_CLR);
            r_load_n <= (w_next != S_LD);
            r_en_n   <= !w_en_next;
            r_rck    <= (w_next == S_CAP);

            if (w_accept) begin
                r_steps <= cmd_steps;
                r_step  <= '0;
                if (cmd_op == OP_LOAD) begin
                    r_datain <= cmd_data;
                end
                if (cmd_op == OP_COUNT) begin
                    r_updown <= cmd_dir;
                end
            end else if (r_state == S_CNT) begin
                r_step <= r_step + 1'b1;
            end

            if (r_state == S_CAP) begin
                r_g_n <= 1'b0;
            end else if (r_state == S_CLR) begin
                r_g_n <= 1'b1;
            end
        end
    end

    cnt_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .cclr_n   (r_cclr_n),
        .load_n   (r_load_n),
        .en_n     (r_en_n),
        .updown   (r_updown),
        .datain   (r_datain),
        .wrap_clr (w_accept),
        .count    (count),
        .wrap     (wrap)
    );

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cclr_n    = r_cclr_n;
    assign load_n    = r_load_n;
    assign enp_n     = r_en_n;
    assign ent_n     = r_en_n;
    assign updown    = r_updown;
    assign datain    = r_datain;
    assign rck       = r_rck;
    assign g_n       = r_g_n;

endmodule : cnt_seq_ctrl
`default_nettype wire

// File: tb/tb_cnt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_seq_ctrl
// Description : Self-checking bench for cnt_seq_ctrl against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_seq_ctrl;

    localparam int W    = 4;
    localparam int SW   = 8;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_dir;
    logic [W-1:0]  cmd_data;
    logic [SW-1:0] cmd_steps;
    logic          cclr_n, load_n, enp_n, ent_n, updown, rck, g_n;
    logic          busy, done, wrap;
    logic [W-1:0]  datain, count;

    int checks = 0;
    int errors = 0;

    // Model: a command is a timeline of k op cycles followed by one DONE cycle.
    bit m_active;
    int m_t, m_k, m_op, m_steps, m_dir, m_data;
    int m_count, m_wrap, m_g, m_updown, m_datain;

    cnt_seq_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_data(cmd_data),
        .cmd_steps(cmd_steps), .cclr_n(cclr_n), .load_n(load_n),
        .enp_n(enp_n), .ent_n(ent_n), .updown(updown), .datain(datain),
        .rck(rck), .g_n(g_n), .busy(busy), .done(done), .count(count),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_t = 0; m_k = 0; m_op = 0; m_steps = 0;
        m_count = 0; m_wrap = 0; m_g = 1; m_updown = 1; m_datain = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (!m_active) begin
            if (cmd_valid) begin
                m_active = 1; m_t = 0; m_wrap = 0;
                m_op = cmd_op; m_steps = cmd_steps; m_dir = cmd_dir; m_data = cmd_data;
                m_k = (m_op == 2) ? ((m_steps == 0) ? 1 : m_steps) : 1;
                if (m_op == 1) m_datain = m_data;
                if (m_op == 2) m_updown = m_dir;
            end
        end else begin
            if (m_t < m_k) begin
                case (m_op)
                    0: begin m_count = 0; m_g = 1; end
                    1: m_count = m_data;
                    3: m_g = 0;
                    default: begin
                        if (m_steps > 0) begin
                            if (m_dir != 0) begin
                                if (m_count == MASK) m_wrap = 1;
                                m_count = (m_count + 1) & MASK;
                            end else begin
                                if (m_count == 0) m_wrap = 1;
                                m_count = (m_count - 1) & MASK;
                            end
                        end
                    end
                endcase
            end
            if (m_t == m_k) m_active = 0;
            else m_t++;
        end
    endtask

    task automatic compare();
        bit opc;
        bit en;
        opc = m_active && (m_t < m_k);
        en  = opc && (m_op == 2) && (m_steps > 0);
        chk("cmd_ready", cmd_ready, !m_active);
        chk("busy", busy, m_active);
        chk("done", done, m_active && (m_t == m_k));
        chk("cclr_n", cclr_n, !(opc && m_op == 0));
        chk("load_n", load_n, !(opc && m_op == 1));
        chk("enp_n", enp_n, !en);
        chk("ent_n", ent_n, !en);
        chk("rck", rck, opc && m_op == 3);
        chk("updown", updown, m_updown);
        chk("datain", datain, m_datain);
        chk("g_n", g_n, m_g);
        chk("count", count, m_count);
        chk("wrap", wrap, m_wrap);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input int op, input int dir, input int data, input int steps,
                        input bit noisy);
        int n;
        cmd_op = op[1:0]; cmd_dir = dir[0]; cmd_data = data[W-1:0];
        cmd_steps = steps[SW-1:0]; cmd_valid = 1'b1;
        n = 0;
        while (!m_active && n < 8) begin cycle(); n++; end
        if (!m_active) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op %0d not accepted in %0d cycles", op, n);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (m_active && n < 400) begin
            if (noisy) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_dir   = 1'($urandom_range(0, 1));
                cmd_data  = W'($urandom_range(0, MASK));
                cmd_steps = SW'($urandom_range(0, 255));
            end
            cycle();
            n++;
        end
        if (m_active) begin
            checks++; errors++;
            $display("FAIL done_timeout: op %0d still busy after %0d cycles", op, n);
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dir = 1'b0;
        cmd_data = '0; cmd_steps = '0;
        model_reset();
        cycle();
        cycle();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_g_n", g_n, 1);
        chk("rst_updown", updown, 1);
        rst = 1'b0;
        cycle();

        send(0, 0, 0, 0, 0);
        chk("clr_count", count, 0);
        chk("clr_g_n", g_n, 1);
        send(1, 0, 'hA, 0, 0);
        chk("ld_count", count, 'hA);
        chk("ld_datain", datain, 'hA);
        send(3, 0, 0, 0, 0);
        chk("cap_g_n", g_n, 0);
        send(1, 0, 'hE, 0, 0);
        send(2, 1, 0, 3, 0);
        chk("up3_count", count, 1);
        chk("up3_wrap", wrap, 1);
        send(1, 0, 'h2, 0, 0);
        send(2, 0, 0, 2, 0);
        chk("dn2_count", count, 0);
        chk("dn2_wrap", wrap, 0);
        send(2, 1, 0, 0, 0);
        chk("zero_count", count, 0);

        // Busy-time command must be ignored: hold a CLEAR request during COUNT.
        cmd_op = 2'd2; cmd_dir = 1'b1; cmd_steps = 8'd5; cmd_valid = 1'b1;
        cycle();
        cmd_op = 2'd0;
        for (int i = 0; i < 6; i++) cycle();
        cmd_valid = 1'b0;
        cycle();
        chk("hold_count", count, 5);
        cycle();

        // Asynchronous reset in the middle of a COUNT.
        send(1, 0, 'hF, 0, 0);
        send(3, 0, 0, 0, 0);
        cmd_op = 2'd2; cmd_dir = 1'b1; cmd_steps = 8'd6; cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        cycle();
        chk("pre_rst_count", count, 1);
        chk("pre_rst_wrap", wrap, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_enp_n", enp_n, 1);
        chk("arst_ent_n", ent_n, 1);
        chk("arst_busy", busy, 0);
        chk("arst_count", count, 0);
        chk("arst_wrap", wrap, 0);
        chk("arst_g_n", g_n, 1);
        model_reset();
        @(negedge clk);
        cycle();
        rst = 1'b0;
        cycle();
        send(0, 0, 0, 0, 0);
        chk("post_rst_count", count, 0);

        for (int i = 0; i < 60; i++) begin
            send($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, MASK),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20), 1'b1);
            for (int j = $urandom_range(0, 2); j > 0; j--) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cnt_seq_ctrl
`default_nettype wire
